// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: walks a glitch engine through a delay x width x repeat
// sweep, arming once per attempt and waiting for the engine or a timeout.
// Each attempt is followed by a cool-down period.
module glitch_sweep_ctrl #(
    parameter int unsigned   DW          = 32,
    parameter int unsigned   WW          = 16,
    parameter logic [DW-1:0] DELAY_START = DW'(0),
    parameter logic [DW-1:0] DELAY_END   = DW'(1000),
    parameter logic [DW-1:0] DELAY_STEP  = DW'(1),
    parameter logic [WW-1:0] WIDTH_START = WW'(1),
    parameter logic [WW-1:0] WIDTH_END   = WW'(12),
    parameter logic [WW-1:0] WIDTH_STEP  = WW'(1),
    parameter int unsigned   REPEATS     = 1,
    parameter int unsigned   SETTLE      = 12_000,
    parameter int unsigned   TIMEOUT     = 12_000_000,
    parameter bit            STOP_ON_HIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          eng_done,
    input  logic          hit,
    output logic [DW-1:0] cfg_delay,
    output logic [WW-1:0] cfg_width,
    output logic          arm,
    output logic          running,
    output logic          sweep_done,
    output logic          hit_flag,
    output logic [15:0]   hit_count,
    output logic [31:0]   attempt_count
);

    localparam int unsigned CW = 32;
    localparam int unsigned RW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_WAIT, S_SETTLE, S_NEXT, S_FINISH
    } state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   rep;
    logic [CW-1:0]   tcnt;
    logic [CW-1:0]   scnt;
    logic            hit_now;
    logic [DW:0]     delay_sum;
    logic [WW:0]     width_sum;
    logic            rep_last, width_last, delay_last;
    logic            wait_expire, settle_end, aborting, starting;

    // Sweep-advance sums are one bit wider so the END bound never wraps.
    always_comb begin
        delay_sum   = {1'b0, cfg_delay} + {1'b0, DELAY_STEP};
        width_sum   = {1'b0, cfg_width} + {1'b0, WIDTH_STEP};
        rep_last    = (rep >= RW'(REPEATS - 1));
        width_last  = (width_sum > {1'b0, WIDTH_END});
        delay_last  = (delay_sum > {1'b0, DELAY_END});
        wait_expire = (tcnt >= CW'(TIMEOUT - 1));
        settle_end  = (SETTLE == 0) || (scnt >= CW'(SETTLE - 1));
        aborting    = abort && (state != S_IDLE);
        starting    = (state == S_IDLE) && start && !abort;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; abort overrides every non-idle state.
    always_comb begin
        state_nx = state;
        if (aborting) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (starting) state_nx = S_LOAD;
                S_LOAD:   state_nx = S_ARM;
                S_ARM:    state_nx = S_WAIT;
                S_WAIT:   if (eng_done || wait_expire) state_nx = S_SETTLE;
                S_SETTLE: if (settle_end)
                              state_nx = (STOP_ON_HIT && hit_now) ? S_FINISH : S_NEXT;
                S_NEXT:   state_nx = (rep_last && width_last && delay_last) ? S_FINISH : S_ARM;
                S_FINISH: state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    // Registered outputs, sweep point, counters and timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_delay     <= DELAY_START;
            cfg_width     <= WIDTH_START;
            arm           <= 1'b0;
            running       <= 1'b0;
            sweep_done    <= 1'b0;
            hit_flag      <= 1'b0;
            hit_count     <= 16'd0;
            attempt_count <= 32'd0;
            rep           <= '0;
            tcnt          <= '0;
            scnt          <= '0;
            hit_now       <= 1'b0;
        end else begin
            arm        <= (state_nx == S_ARM);
            running    <= (state_nx != S_IDLE);
            sweep_done <= (state_nx == S_FINISH);
            if (!aborting) begin
                case (state)
                    S_IDLE: if (starting) begin
                        hit_flag      <= 1'b0;
                        hit_count     <= 16'd0;
                        attempt_count <= 32'd0;
                        rep           <= '0;
                        cfg_delay     <= DELAY_START;
                        cfg_width     <= WIDTH_START;
                    end
                    S_LOAD: begin
                        cfg_delay <= DELAY_START;
                        cfg_width <= WIDTH_START;
                    end
                    S_ARM: begin
                        tcnt    <= '0;
                        hit_now <= 1'b0;
                    end
                    S_WAIT: begin
                        if (eng_done) begin
                            attempt_count <= attempt_count + 32'd1;
                            scnt          <= '0;
                            if (hit) begin
                                hit_now  <= 1'b1;
                                hit_flag <= 1'b1;
                                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                            end
                        end else if (wait_expire) begin
                            attempt_count <= attempt_count + 32'd1;
                            scnt          <= '0;
                        end else begin
                            tcnt <= tcnt + CW'(1);
                        end
                    end
                    S_SETTLE: scnt <= scnt + CW'(1);
                    S_NEXT: begin
                        if (!rep_last) begin
                            rep <= rep + RW'(1);
                        end else begin
                            rep <= '0;
                            if (!width_last) begin
                                cfg_width <= width_sum[WW-1:0];
                            end else begin
                                cfg_width <= WIDTH_START;
                                if (!delay_last) cfg_delay <= delay_sum[DW-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Bench for glitch_sweep_ctrl: three instances (plain sweep, stop-on-hit,
// narrow delay field at its maximum), a randomized engine and a loop model.
module tb_glitch_sweep_ctrl;

    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_v = 3'b0;
    logic [2:0] abort_v = 3'b0;
    logic       eng_done = 1'b0;
    logic       hit = 1'b0;

    logic [31:0] a_d, b_d, a_ac, b_ac, c_ac;
    logic [15:0] a_w, b_w, a_hc, b_hc, c_hc;
    logic [7:0]  c_d;
    logic [3:0]  c_w;
    logic a_arm, a_run, a_sd, a_hf;
    logic b_arm, b_run, b_sd, b_hf;
    logic c_arm, c_run, c_sd, c_hf;

    glitch_sweep_ctrl #(.DELAY_START(32'd10), .DELAY_END(32'd30), .DELAY_STEP(32'd10),
        .WIDTH_START(16'd2), .WIDTH_END(16'd4), .WIDTH_STEP(16'd2), .REPEATS(2),
        .SETTLE(3), .TIMEOUT(TO), .STOP_ON_HIT(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .eng_done(eng_done), .hit(hit), .cfg_delay(a_d), .cfg_width(a_w),
        .arm(a_arm), .running(a_run), .sweep_done(a_sd), .hit_flag(a_hf),
        .hit_count(a_hc), .attempt_count(a_ac));

    glitch_sweep_ctrl #(.DELAY_START(32'd10), .DELAY_END(32'd30), .DELAY_STEP(32'd10),
        .WIDTH_START(16'd2), .WIDTH_END(16'd4), .WIDTH_STEP(16'd2), .REPEATS(2),
        .SETTLE(0), .TIMEOUT(TO), .STOP_ON_HIT(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .eng_done(eng_done), .hit(hit), .cfg_delay(b_d), .cfg_width(b_w),
        .arm(b_arm), .running(b_run), .sweep_done(b_sd), .hit_flag(b_hf),
        .hit_count(b_hc), .attempt_count(b_ac));

    glitch_sweep_ctrl #(.DW(8), .WW(4), .DELAY_START(8'd250), .DELAY_END(8'd255),
        .DELAY_STEP(8'd3), .WIDTH_START(4'd1), .WIDTH_END(4'd1), .WIDTH_STEP(4'd1),
        .REPEATS(1), .SETTLE(1), .TIMEOUT(TO), .STOP_ON_HIT(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
        .eng_done(eng_done), .hit(hit), .cfg_delay(c_d), .cfg_width(c_w),
        .arm(c_arm), .running(c_run), .sweep_done(c_sd), .hit_flag(c_hf),
        .hit_count(c_hc), .attempt_count(c_ac));

    // Sweep parameters of each instance, as seen by the model.
    longint p_ds [3] = '{10, 10, 250};
    longint p_de [3] = '{30, 30, 255};
    longint p_dt [3] = '{10, 10, 3};
    longint p_ws [3] = '{2, 2, 1};
    longint p_we [3] = '{4, 4, 1};
    longint p_wt [3] = '{2, 2, 1};
    int     p_rp [3] = '{2, 2, 1};
    int     p_st [3] = '{3, 0, 1};
    bit     p_sh [3] = '{1'b0, 1'b1, 1'b0};

    int cur = 0;
    logic [31:0] m_d, m_ac;
    logic [15:0] m_w, m_hc;
    logic m_arm, m_run, m_sd, m_hf;

    // Observe the instance under test.
    always_comb begin
        case (cur)
            1: begin m_d = b_d; m_w = b_w; m_arm = b_arm; m_run = b_run; m_sd = b_sd;
                     m_hf = b_hf; m_hc = b_hc; m_ac = b_ac; end
            2: begin m_d = {24'd0, c_d}; m_w = {12'd0, c_w}; m_arm = c_arm; m_run = c_run;
                     m_sd = c_sd; m_hf = c_hf; m_hc = c_hc; m_ac = c_ac; end
            default: begin m_d = a_d; m_w = a_w; m_arm = a_arm; m_run = a_run; m_sd = a_sd;
                     m_hf = a_hf; m_hc = a_hc; m_ac = a_ac; end
        endcase
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (inst %0d, t=%0t)", tag, got, exp, cur, $time);
        end
    endtask

    task automatic check_reset(input int sel);
        cur = sel;
        #1;
        check("rst_delay", m_d, p_ds[sel]);
        check("rst_width", m_w, p_ws[sel]);
        check("rst_arm", m_arm, 0);
        check("rst_run", m_run, 0);
        check("rst_done", m_sd, 0);
        check("rst_hflag", m_hf, 0);
        check("rst_hcnt", m_hc, 0);
        check("rst_acnt", m_ac, 0);
    endtask

    // One sweep. mode 1: engine never answers. hit_at: 0 none, -1 random,
    // n>0 only on attempt n. abort_at / rst_at: attempt index, -1 disables.
    task automatic run_sweep(input int sel, input int mode, input int hit_at,
                             input int abort_at, input int rst_at);
        int  k = 0;
        int  hc = 0;
        bit  hf = 1'b0;
        bit  stopped = 1'b0;
        int  lat;
        bit  h;
        int  sc;
        cur = sel;
        sc = (p_st[sel] > 0) ? p_st[sel] : 1;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        check("load_run", m_run, 1);
        check("load_arm", m_arm, 0);
        check("load_delay", m_d, p_ds[sel]);
        @(negedge clk);
        for (longint d = p_ds[sel]; d <= p_de[sel] && !stopped; d += p_dt[sel])
            for (longint w = p_ws[sel]; w <= p_we[sel] && !stopped; w += p_wt[sel])
                for (int r = 0; r < p_rp[sel] && !stopped; r++) begin
                    k++;
                    check("arm", m_arm, 1);
                    check("cfg_delay", m_d, d);
                    check("cfg_width", m_w, w);
                    lat = (mode == 1 || k == abort_at) ? 0 : int'($urandom_range(1, TO));
                    h = (hit_at < 0) ? ($urandom_range(0, 3) == 0) : (k == hit_at);
                    for (int i = 1; i <= TO; i++) begin
                        @(negedge clk);
                        if (k == abort_at && i == 2) begin
                            abort_v[sel] = 1'b1;
                            start_v[sel] = 1'b0;
                            hit = 1'b0;
                            @(negedge clk);
                            abort_v[sel] = 1'b0;
                            check("abort_run", m_run, 0);
                            check("abort_acnt", m_ac, k - 1);
                            for (int j = 0; j < 30; j++) begin
                                @(negedge clk);
                                if (m_arm !== 1'b0 || m_sd !== 1'b0) check("abort_quiet", {m_arm, m_sd}, 0);
                            end
                            check("abort_idle", m_run, 0);
                            return;
                        end
                        check("wait_arm", m_arm, 0);
                        check("wait_run", m_run, 1);
                        start_v[sel] = 1'($urandom_range(0, 1));
                        if (i == lat) begin
                            eng_done = 1'b1;
                            hit = h;
                            break;
                        end
                        hit = 1'($urandom_range(0, 1));
                    end
                    if (lat != 0 && h) begin
                        hc++;
                        hf = 1'b1;
                    end
                    @(negedge clk);
                    eng_done = 1'b0;
                    hit = 1'b0;
                    start_v[sel] = 1'b0;
                    check("acnt", m_ac, k);
                    check("hcnt", m_hc, hc);
                    check("hflag", m_hf, hf);
                    if (k == rst_at) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check_reset(sel);
                        eng_done = 1'b1;
                        hit = 1'b1;
                        @(negedge clk);
                        eng_done = 1'b0;
                        hit = 1'b0;
                        @(negedge clk);
                        check("idle_run", m_run, 0);
                        check("idle_acnt", m_ac, 0);
                        check("idle_hcnt", m_hc, 0);
                        return;
                    end
                    for (int s = 0; s < sc; s++) begin
                        if ($urandom_range(0, 1) == 1) begin
                            eng_done = 1'b1;
                            hit = 1'b1;
                        end
                        @(negedge clk);
                        eng_done = 1'b0;
                        hit = 1'b0;
                    end
                    if (p_sh[sel] && lat != 0 && h) begin
                        stopped = 1'b1;
                    end else begin
                        check("next_arm", m_arm, 0);
                        check("next_acnt", m_ac, k);
                        @(negedge clk);
                    end
                end
        check("fin_done", m_sd, 1);
        check("fin_run", m_run, 1);
        check("fin_arm", m_arm, 0);
        @(negedge clk);
        check("end_done", m_sd, 0);
        check("end_run", m_run, 0);
        check("end_acnt", m_ac, k);
        check("end_hcnt", m_hc, hc);
        check("end_hflag", m_hf, hf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);
        check_reset(2);
        run_sweep(0, 0, 0, -1, -1);
        run_sweep(0, 0, 3, -1, -1);
        run_sweep(1, 0, 3, -1, -1);
        run_sweep(0, 1, 0, -1, -1);
        run_sweep(0, 0, -1, -1, -1);
        run_sweep(0, 0, 0, 5, -1);
        run_sweep(0, 0, 0, -1, -1);
        // Start and abort together in IDLE: stays idle.
        cur = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("sa_run", m_run, 0);
        @(negedge clk);
        check("sa_arm", m_arm, 0);
        run_sweep(0, 0, -1, -1, 7);
        run_sweep(2, 0, -1, -1, -1);
        run_sweep(1, 0, -1, -1, -1);
        run_sweep(1, 1, 0, -1, -1);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_sweep_ctrl.md
# glitch_sweep_ctrl

Sequencer that drives a runtime-configurable glitch engine through a parameter sweep: an outer loop over trigger-to-glitch delay, an inner loop over glitch width, and a fixed repeat count per (delay, width) point. For each attempt it loads the configuration, arms the engine and waits for completion or timeout. It then samples a target-fault indication and enforces a cool-down before the next attempt. It sits between the operator controls (start/abort) and the glitch engine, replacing the fixed DELAY/GWIDTH build-time values with a scheduled search.

## Interface
- DW, 32: delay/config width in bits (clk cycles).
- WW, 16: glitch width field in bits.
- DELAY_START, 0: first delay value.
- DELAY_END, 1000: last delay value (inclusive bound).
- DELAY_STEP, 1: delay increment, nonzero.
- WIDTH_START, 1: first width value.
- WIDTH_END, 12: last width value (inclusive bound).
- WIDTH_STEP, 1: width increment, nonzero.
- REPEATS, 1: attempts per (delay, width) point, 1..255.
- SETTLE, 12_000: cool-down cycles after each attempt, 0 allowed.
- TIMEOUT, 12_000_000: max cycles in WAIT before the attempt is abandoned.
- STOP_ON_HIT, 0: 1 ends the sweep after the first hit.
- clk  in  1  system clock (12 MHz oscillator domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  terminate sweep from any state.
- eng_done  in  1  one-cycle pulse from engine: glitch emitted.
- hit  in  1  target fault indication, sampled in the eng_done cycle.
- cfg_delay  out  DW  delay presented to engine.
- cfg_width  out  WW  glitch width presented to engine.
- arm  out  1  one-cycle pulse: engine arms with current cfg.
- running  out  1  high in every state except IDLE.
- sweep_done  out  1  one-cycle pulse on normal completion.
- hit_flag  out  1  sticky: at least one hit since last start.
- hit_count  out  16  hits since last start, saturating at 16'hFFFF.
- attempt_count  out  32  completed attempts (done or timeout) since last start.

## Operation
- States: IDLE, LOAD, ARM, WAIT, SETTLE, NEXT, FINISH.
- IDLE: start=1 (and abort=0) -> LOAD; clears hit_flag, hit_count, attempt_count, repeat counter.
- LOAD: cfg_delay<=DELAY_START, cfg_width<=WIDTH_START -> ARM.
- ARM: arm=1 for exactly this cycle; timeout counter cleared -> WAIT.
- WAIT: eng_done -> sample hit (hit_count++ saturating, hit_flag<=1), attempt_count++ -> SETTLE. Timeout counter reaching TIMEOUT-1 without eng_done -> attempt_count++, no hit -> SETTLE. eng_done in the expiry cycle counts as done.
- SETTLE: hold SETTLE cycles (0 -> single pass-through cycle) -> NEXT; if STOP_ON_HIT and a hit occurred this attempt -> FINISH instead.
- NEXT: repeat counter < REPEATS-1 -> increment, ARM. Otherwise repeat<=0 and advance width; width+WIDTH_STEP > WIDTH_END -> width<=WIDTH_START and advance delay; delay+DELAY_STEP > DELAY_END -> FINISH, else ARM.
- Advance comparisons use DW+1 / WW+1 bit sums; no wrap-around past END.
- FINISH: sweep_done=1 for one cycle -> IDLE.
- abort: any non-IDLE state -> IDLE next cycle; arm not asserted, sweep_done not asserted; counters and cfg retain values. Abort and start together in IDLE: stay IDLE.
- eng_done/hit outside WAIT ignored. start while running ignored.

## Timing
- Reset values: state IDLE, cfg_delay=DELAY_START, cfg_width=WIDTH_START, arm=0, running=0, sweep_done=0, hit_flag=0, hit_count=0, attempt_count=0.
- start cycle N -> LOAD at N+1, arm pulse at N+2.
- cfg_delay/cfg_width are registered and stable from one cycle before arm until the NEXT cycle after that attempt.
- Attempt-to-attempt, SETTLE=0, same point: eng_done at cycle M -> arm at M+3 (SETTLE, NEXT, ARM).
- sweep_done appears one cycle after the final NEXT (or SETTLE with STOP_ON_HIT); running drops the following cycle.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- DELAY 10..30 step 10, WIDTH 2..4 step 2, REPEATS 2, engine returns eng_done 5 cycles after arm, hit=0 -> 12 arm pulses; cfg order (10,2)x2,(10,4)x2,(20,2)x2,…,(30,4)x2; attempt_count=12; one sweep_done; hit_count=0.
- Same setup, hit=1 on the 3rd eng_done only -> hit_count=1, hit_flag=1, sweep runs to completion; with STOP_ON_HIT=1 -> sweep_done after attempt 3, attempt_count=3.
- eng_done never asserted, TIMEOUT=20 -> each arm followed by WAIT lasting 20 cycles; attempt_count increments, hit_count=0, sweep completes.
- abort asserted during 5th WAIT -> IDLE next cycle, no further arm, no sweep_done, attempt_count=4; subsequent start clears counters and restarts at (10,2).
- rst asserted mid-SETTLE -> next cycle all outputs at reset values; eng_done pulse in IDLE ignored.
- DELAY_END=DW max value with DELAY_STEP=3 -> no overflow wrap; sweep terminates after last in-range delay.
